// File: rtl/norm_sched_pkg.sv
// Shared constants for the normalizer channel scheduler: sample widths,
// normalizer pipeline depth, the normalizer offset and a channel-id width helper.
package norm_sched_pkg;

   localparam int INPUT_WIDTH = 32;
   localparam int DATA_WIDTH  = 27;
   localparam int NORM_LAT    = 4;
   localparam int OFFSET      = (1 << 18) - 1;

   // Width of a channel index; never less than one bit so a lone channel still has an id
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/norm_channel_scheduler_if.sv
// Bundle of channel-side, normalizer-side and NN-side signals of the scheduler.
// The master side is the surrounding system (channels, normalizer, NN), the slave side is the scheduler.
interface norm_channel_scheduler_if
   import norm_sched_pkg::*;
#(
   parameter int NUM_CH = 4
);

   localparam int CH_W = ch_w(NUM_CH);

   logic [NUM_CH-1:0]               ch_stb;
   logic [NUM_CH*2*INPUT_WIDTH-1:0] ch_data;
   logic                            nn_ready;
   logic                            clr_ovf;
   logic [NUM_CH-1:0]               ch_pending;
   logic [NUM_CH-1:0]               ch_ovf;
   logic [2*INPUT_WIDTH-1:0]        norm_in;
   logic [2*DATA_WIDTH-1:0]         norm_out;
   logic                            out_valid;
   logic [CH_W-1:0]                 out_ch;
   logic [2*DATA_WIDTH-1:0]         out_data;

   modport master (
      output ch_stb, ch_data, nn_ready, clr_ovf, norm_out,
      input  ch_pending, ch_ovf, norm_in, out_valid, out_ch, out_data
   );

   modport slave (
      input  ch_stb, ch_data, nn_ready, clr_ovf, norm_out,
      output ch_pending, ch_ovf, norm_in, out_valid, out_ch, out_data
   );

endinterface

// File: rtl/norm_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after the
// pointer (wrapping), and moves the pointer just past the winner.
module rr_arbiter
   import norm_sched_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              en,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic              grant_vld
);

   logic [CH_W-1:0] ptr;
   logic [CH_W:0]   cand;
   logic            found;

   // Scan requests starting at the pointer; the extra bit of cand absorbs the wrap before folding back
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      grant     = '0;
      cand      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, ptr} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH)) begin
            cand = cand - (CH_W+1)'(NUM_CH);
         end
         if (!found && req[cand[CH_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[CH_W-1:0];
         end
      end
      grant_vld = en & found;
      if (grant_vld) begin
         grant[grant_idx] = 1'b1;
      end
   end

   // Pointer advances only on a real grant, to the channel after the winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_vld) begin
         ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/norm_channel_scheduler.sv
// Shares one normalizer among NUM_CH readout channels: latches each channel's
// sample, grants one per cycle round-robin, and tags the sample with its channel
// so the normalized result leaves with the right id. Sample bits are never altered here.
module norm_channel_scheduler
   import norm_sched_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input logic                     clk,
   input logic                     rst,
   norm_channel_scheduler_if.slave bus
);

   localparam int CH_W = ch_w(NUM_CH);
   localparam int SW   = 2 * INPUT_WIDTH;

   logic [SW-1:0]           hold [NUM_CH];
   logic [NUM_CH-1:0]       pending;
   logic [NUM_CH-1:0]       ovf;
   logic [NUM_CH-1:0]       grant;
   logic [CH_W-1:0]         grant_idx;
   logic                    grant_vld;
   logic [SW-1:0]           norm_in;
   logic                    tag_vld [NORM_LAT];
   logic [CH_W-1:0]         tag_ch  [NORM_LAT];
   logic                    out_valid;
   logic [CH_W-1:0]         out_ch;
   logic [2*DATA_WIDTH-1:0] out_data;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (pending),
      .en        (bus.nn_ready),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // Latch a strobed sample when the slot is free or being granted this cycle; otherwise keep the older one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            hold[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (bus.ch_stb[k] && (!pending[k] || grant[k])) begin
               hold[k]    <= bus.ch_data[k*SW +: SW];
               pending[k] <= 1'b1;
            end else if (grant[k]) begin
               pending[k] <= 1'b0;
            end
         end
      end
   end

   // Sticky overflow for a dropped strobe; a new drop beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (bus.ch_stb[k] && pending[k] && !grant[k]) begin
               ovf[k] <= 1'b1;
            end else if (bus.clr_ovf) begin
               ovf[k] <= 1'b0;
            end
         end
      end
   end

   // Normalizer input register loads the winner's sample and otherwise holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         norm_in <= '0;
      end else if (grant_vld) begin
         norm_in <= hold[grant_idx];
      end
   end

   // Tag pipe shadows the normalizer pipeline; it never stalls, so in-flight tags always advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NORM_LAT; i++) begin
            tag_vld[i] <= 1'b0;
            tag_ch[i]  <= '0;
         end
      end else begin
         tag_vld[0] <= grant_vld;
         tag_ch[0]  <= grant_idx;
         for (int i = 1; i < NORM_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_ch[i]  <= tag_ch[i-1];
         end
      end
   end

   // Output register captures the normalized result together with its tag; id and data hold between samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
      end else if (tag_vld[NORM_LAT-1]) begin
         out_valid <= 1'b1;
         out_ch    <= tag_ch[NORM_LAT-1];
         out_data  <= bus.norm_out;
      end else begin
         out_valid <= 1'b0;
      end
   end

   assign bus.ch_pending = pending;
   assign bus.ch_ovf     = ovf;
   assign bus.norm_in    = norm_in;
   assign bus.out_valid  = out_valid;
   assign bus.out_ch     = out_ch;
   assign bus.out_data   = out_data;

endmodule
